// File: rtl/aux_int_request.sv
// rtl/aux_int_request.sv - button synchroniser/debouncer feeding a priority-encoded interrupt request
module aux_int_request #(
    parameter int NumCh       = 3,
    parameter int DebounceCnt = 4,
    parameter int IdBit       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NumCh-1:0] btn,
    input  logic             clear,
    input  logic             ack,
    output logic             req_valid,
    output logic [IdBit-1:0] req_id,
    output logic [NumCh-1:0] pending,
    output logic [NumCh-1:0] level
);

    localparam int CntW = $clog2(DebounceCnt + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        WAITREL = 2'd2
    } state_e;

    logic [NumCh-1:0] s1_q, s2_q;
    logic [NumCh-1:0] level_q, level_d;
    logic [NumCh-1:0] level_prev_q;
    logic [CntW-1:0]  cnt_q [NumCh];
    logic [CntW-1:0]  cnt_d [NumCh];
    state_e           state_q [NumCh];
    state_e           state_d [NumCh];
    logic             grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            s1_q         <= btn;
            s2_q         <= s1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Level only changes after DebounceCnt consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NumCh; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign grant = ack & req_valid;

    // clear takes precedence over ack; a channel still held must be released before re-arming.
    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (level_q[i] && !level_prev_q[i]) state_d[i] = PEND;
                end
                PEND: begin
                    if (clear) begin
                        state_d[i] = level_q[i] ? WAITREL : IDLE;
                    end else if (grant && (req_id == IdBit'(i))) begin
                        state_d[i] = WAITREL;
                    end
                end
                WAITREL: begin
                    if (!level_q[i]) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NumCh; i++) begin
            pending[i] = (state_q[i] == PEND);
        end
    end

    always_comb begin
        req_id = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (pending[i]) req_id = IdBit'(i);
        end
    end

    assign req_valid = |pending;
    assign level     = level_q;

endmodule

// File: tb/tb_aux_int_request.sv
// tb/tb_aux_int_request.sv - self-checking bench for aux_int_request
module tb_aux_int_request;

    localparam int NCH = 3;
    localparam int DB  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] btn = '0;
    logic           clear = 1'b0;
    logic           ack = 1'b0;
    logic           req_valid;
    logic [1:0]     req_id;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] level;

    int errors = 0;
    int checks = 0;

    aux_int_request #(.NumCh(NCH), .DebounceCnt(DB), .IdBit(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .clear     (clear),
        .ack       (ack),
        .req_valid (req_valid),
        .req_id    (req_id),
        .pending   (pending),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference model: each channel remembers the synchronised samples, how long the
    // sample has disagreed with the clean level, and whether it owes a request or a release.
    logic [NCH-1:0] m_s1, m_s2, m_lvl, m_prev, m_pend, m_hold;
    int             m_run [NCH];
    bit             m_on = 1'b0;

    function automatic int lowest(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0; m_pend = '0; m_hold = '0;
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
            m_on = 1'b1;
        end else if (m_on) begin
            automatic int gid = lowest(m_pend);
            automatic bit any = |m_pend;
            automatic logic [NCH-1:0] lvl_old = m_lvl;
            for (int i = 0; i < NCH; i++) begin
                if (m_pend[i]) begin
                    if (clear) begin
                        m_pend[i] = 1'b0;
                        m_hold[i] = lvl_old[i];
                    end else if (ack && any && gid == i) begin
                        m_pend[i] = 1'b0;
                        m_hold[i] = 1'b1;
                    end
                end else if (m_hold[i]) begin
                    if (!lvl_old[i]) m_hold[i] = 1'b0;
                end else if (lvl_old[i] && !m_prev[i]) begin
                    m_pend[i] = 1'b1;
                end
                if (m_s2[i] == lvl_old[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] + 1 == DB) begin
                    m_lvl[i] = ~lvl_old[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end
            m_prev = lvl_old;
            m_s2 = m_s1;
            m_s1 = btn;
        end
        #1;
        if (m_on) begin
            checks++;
            if (pending !== m_pend || level !== m_lvl || req_valid !== (|m_pend) ||
                req_id !== 2'(lowest(m_pend))) begin
                errors++;
                $display("FAIL model t=%0t pending=%b/%b level=%b/%b valid=%b/%b id=%0d/%0d (actual/required)",
                         $time, pending, m_pend, level, m_lvl, req_valid, |m_pend, req_id, lowest(m_pend));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = '0; ack = 1'b0; clear = 1'b0;
        ticks(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] btn;
        logic       ack;
        logic [2:0] exp_pend;
        logic [2:0] exp_lvl;
        logic       exp_valid;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Row k: inputs applied before edge k after reset release, outputs checked after it.
        for (int k = 0; k < 10; k++) begin
            vecs[k].btn       = 3'b001;
            vecs[k].ack       = (k == 7);
            vecs[k].exp_pend  = (k == 6) ? 3'b001 : 3'b000;
            vecs[k].exp_lvl   = (k >= 5) ? 3'b001 : 3'b000;
            vecs[k].exp_valid = (k == 6);
            vecs[k].exp_id    = 2'd0;
        end

        do_reset();
        chk("reset_pending", 8'(pending), 8'h0);
        chk("reset_level", 8'(level), 8'h0);
        chk("reset_valid", 8'(req_valid), 8'h0);
        chk("reset_id", 8'(req_id), 8'h0);

        // Single press, ack, no re-request while held.
        for (int k = 0; k < 10; k++) begin
            btn = vecs[k].btn;
            ack = vecs[k].ack;
            tick();
            chk($sformatf("s1_pend_e%0d", k + 1), 8'(pending), 8'(vecs[k].exp_pend));
            chk($sformatf("s1_lvl_e%0d", k + 1), 8'(level), 8'(vecs[k].exp_lvl));
            chk($sformatf("s1_valid_e%0d", k + 1), 8'(req_valid), 8'(vecs[k].exp_valid));
            chk($sformatf("s1_id_e%0d", k + 1), 8'(req_id), 8'(vecs[k].exp_id));
        end
        ack = 1'b0;

        // Glitch shorter than the debounce time, then a just-long-enough pulse.
        do_reset();
        btn = 3'b010; ticks(3);
        btn = 3'b000; ticks(8);
        chk("s2_glitch_lvl", 8'(level), 8'h0);
        chk("s2_glitch_pend", 8'(pending), 8'h0);
        btn = 3'b010; ticks(4);
        btn = 3'b000; ticks(4);
        chk("s2_pulse_pend", 8'(pending), 8'h2);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("s2_pulse_acked", 8'(pending), 8'h0);
        ticks(8);

        // Priority between two channels.
        do_reset();
        btn = 3'b100; ticks(2);
        btn = 3'b101; ticks(10);
        chk("s3_pend", 8'(pending), 8'h5);
        chk("s3_id0", 8'(req_id), 8'h0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("s3_id2", 8'(req_id), 8'h2);
        chk("s3_valid", 8'(req_valid), 8'h1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("s3_empty", 8'(req_valid), 8'h0);
        btn = 3'b000; ticks(8);

        // ack of ch0 coinciding with ch1's level rise.
        do_reset();
        btn = 3'b001; ticks(7);
        chk("s4_pre", 8'(pending), 8'h1);
        btn = 3'b011; ticks(5);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("s4_lvl", 8'(level), 8'h3);
        chk("s4_mid", 8'(pending), 8'h0);
        tick();
        chk("s4_post", 8'(pending), 8'h2);
        btn = 3'b000; ack = 1'b1; tick(); ack = 1'b0; ticks(8);

        // clear with one channel held and one released.
        do_reset();
        btn = 3'b011; ticks(7);
        chk("s5_pre", 8'(pending), 8'h3);
        btn = 3'b001; ticks(8);
        chk("s5_still", 8'(pending), 8'h3);
        clear = 1'b1; ack = 1'b1; tick(); clear = 1'b0; ack = 1'b0;
        chk("s5_clear", 8'(pending), 8'h0);
        ticks(6);
        chk("s5_noreq", 8'(pending), 8'h0);
        btn = 3'b011; ticks(7);
        chk("s5_ch1_again", 8'(pending), 8'h2);
        ack = 1'b1; tick(); ack = 1'b0;
        btn = 3'b010; ticks(8);
        btn = 3'b011; ticks(7);
        chk("s5_ch0_again", 8'(pending), 8'h1);
        btn = 3'b000; ack = 1'b1; tick(); ack = 1'b0; ticks(8);

        // Reset in the middle of a debounce.
        do_reset();
        btn = 3'b001; ticks(4);
        rst = 1'b1; tick();
        chk("s6_rst_pend", 8'(pending), 8'h0);
        chk("s6_rst_lvl", 8'(level), 8'h0);
        chk("s6_rst_valid", 8'(req_valid), 8'h0);
        rst = 1'b0; ticks(6);
        chk("s6_e6_pend", 8'(pending), 8'h0);
        chk("s6_e6_lvl", 8'(level), 8'h1);
        tick();
        chk("s6_e7_pend", 8'(pending), 8'h1);

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            ack   = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 40) == 0);
            rst   = ($urandom_range(0, 700) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; clear = 1'b0;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
